// File: rtl/alu_multicycle.sv
// alu_multicycle - execute-stage ALU with start/busy/done handshake.
//
// Logic and add/sub/compare opcodes complete in one edge. Unsigned multiply
// (low/high word) and divide/remainder run iteratively, one bit per edge,
// finishing WIDTH+1 edges after the start edge.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   start        operation request, sampled only while busy=0
//   alucode      operation select, latched with start
//   data1        operand A / dividend, latched with start
//   data2        operand B / divisor, latched with start
//   busy         high while an iterative operation is running
//   done         one-cycle pulse, result and flags valid
//   dataOut      registered result, held until the next done
//   zero         registered (dataOut == 0)
//   div_by_zero  registered, set with done for DIVU/REMU with divisor 0
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alucode,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dataOut,
  output logic             zero,
  output logic             div_by_zero
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [3:0]         op_q;
  // hi_q: upper product word / partial remainder
  // lo_q: multiplier shifting out, product low word / dividend shifting out, quotient
  // b_q : multiplicand / divisor
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   data_q;
  logic               done_q;
  logic               busy_q;
  logic               zero_q;
  logic               dbz_q;

  logic [WIDTH-1:0]   hi_d;
  logic [WIDTH-1:0]   lo_d;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH-1:0]   div_diff_s;
  logic               div_ge_s;
  logic [WIDTH-1:0]   iter_res_s;
  logic [WIDTH-1:0]   simple_res_s;
  logic               is_iter_s;

  // Single-cycle opcodes; unknown codes yield zero.
  function automatic logic [WIDTH-1:0] simple_op(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = (a < b) ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b0}};
      4'b1100: r = ~(a | b);
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  // Decode of the incoming request and its single-cycle result.
  always_comb begin
    is_iter_s    = (alucode[3:2] == 2'b10);
    simple_res_s = simple_op(alucode, data1, data2);
  end

  // One iteration step: shift-add multiply or restoring shift-subtract divide.
  always_comb begin
    mul_sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    div_shift_s = {hi_q, lo_q[WIDTH-1]};
    div_ge_s    = (div_shift_s >= {1'b0, b_q});
    // The restored remainder is always below the divisor, so WIDTH bits suffice.
    div_diff_s  = div_shift_s[WIDTH-1:0] - b_q;
    if (op_q[1]) begin
      hi_d = div_ge_s ? div_diff_s : div_shift_s[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], div_ge_s};
    end else begin
      hi_d = mul_sum_s[WIDTH:1];
      lo_d = {mul_sum_s[0], lo_q[WIDTH-1:1]};
    end
    // op_q[0] picks the high word (MULHI) or remainder (REMU).
    case (op_q[0])
      1'b1:    iter_res_s = hi_d;
      default: iter_res_s = lo_d;
    endcase
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      op_q    <= 4'b0000;
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      data_q  <= {WIDTH{1'b0}};
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      zero_q  <= 1'b1;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && is_iter_s) begin
            op_q    <= alucode;
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= data1;
            b_q     <= data2;
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= CALC;
          end else if (start) begin
            data_q  <= simple_res_s;
            zero_q  <= (simple_res_s == {WIDTH{1'b0}});
            dbz_q   <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            done_q  <= 1'b0;
          end
        end
        CALC: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == LAST_CNT) begin
            data_q  <= iter_res_s;
            zero_q  <= (iter_res_s == {WIDTH{1'b0}});
            dbz_q   <= op_q[1] && (b_q == {WIDTH{1'b0}});
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign dataOut     = data_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=32): directed cases plus
// random operations, checked by a scoreboard queue against a reference model.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  alucode;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        busy;
  logic        done;
  logic [31:0] dataOut;
  logic        zero;
  logic        div_by_zero;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [32:0] exp_q[$];   // {div_by_zero, result}

  alu_multicycle #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .alucode(alucode),
    .data1(data1), .data2(data2), .busy(busy), .done(done),
    .dataOut(dataOut), .zero(zero), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference model: plain 64-bit arithmetic on the opcode table.
  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      4'b0000: return {1'b0, a & b};
      4'b0001: return {1'b0, a | b};
      4'b0010: return {1'b0, 32'(a + b)};
      4'b0110: return {1'b0, 32'(a - b)};
      4'b0111: return {1'b0, (a < b) ? 32'd1 : 32'd0};
      4'b1100: return {1'b0, ~(a | b)};
      4'b1000: return {1'b0, p[31:0]};
      4'b1001: return {1'b0, p[63:32]};
      4'b1010: return (b == 32'd0) ? {1'b1, 32'hFFFF_FFFF} : {1'b0, a / b};
      4'b1011: return (b == 32'd0) ? {1'b1, a} : {1'b0, a % b};
      default: return 33'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 dataOut=0x%0h, expected no done", dataOut);
      end else begin
        e = exp_q.pop_front();
        chk("dataOut", 64'(dataOut), 64'(e[31:0]));
        chk("zero", 64'(zero), 64'(e[31:0] == 32'd0));
        chk("div_by_zero", 64'(div_by_zero), 64'(e[32]));
      end
    end
  end

  // Issue one op from the current time; checks latency and busy-cycle count.
  // With disturb set, start is pulsed with new operands while the op runs.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb);
    int lat;
    int bcnt;
    bit iter;
    iter = (op[3:2] == 2'b10);
    exp_q.push_back(model(op, a, b));
    alucode = op;
    data1   = a;
    data2   = b;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    bcnt  = busy ? 1 : 0;
    while (!done && lat < 60) begin
      if (disturb && (lat == 5 || lat == 10)) begin
        alucode = 4'b0010;
        data1   = $urandom;
        data2   = $urandom;
        start   = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (busy) bcnt++;
    end
    start = 1'b0;
    chk("latency", 64'(lat), iter ? 64'd33 : 64'd1);
    chk("busy_cycles", 64'(bcnt), iter ? 64'd32 : 64'd0);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          dcnt;
    reset = 1'b1; start = 1'b0; alucode = 4'b0000; data1 = 32'd0; data2 = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dataOut", 64'(dataOut), 64'd0);
    chk("rst_zero", 64'(zero), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk); reset = 1'b0;

    // Single-cycle opcodes
    @(negedge clk); run_op(4'b0010, 32'hFFFF_FFFF, 32'd1, 1'b0);
    @(negedge clk); run_op(4'b0110, 32'd5, 32'd7, 1'b0);
    @(negedge clk); run_op(4'b0111, 32'd3, 32'd7, 1'b0);
    @(negedge clk); run_op(4'b0101, 32'd3, 32'd7, 1'b0);
    // Multiply
    @(negedge clk); run_op(4'b1000, 32'h0001_0000, 32'h0001_0000, 1'b0);
    @(negedge clk); run_op(4'b1001, 32'h0001_0000, 32'h0001_0000, 1'b0);
    @(negedge clk); run_op(4'b1000, 32'd12345, 32'd678, 1'b0);
    // Divide
    @(negedge clk); run_op(4'b1010, 32'd100, 32'd7, 1'b0);
    @(negedge clk); run_op(4'b1011, 32'd100, 32'd7, 1'b0);
    @(negedge clk); run_op(4'b1010, 32'hFFFF_FFFF, 32'd1, 1'b0);
    @(negedge clk); run_op(4'b1010, 32'd55, 32'd0, 1'b0);
    @(negedge clk); run_op(4'b1011, 32'd55, 32'd0, 1'b0);
    @(negedge clk); run_op(4'b0010, 32'd1, 32'd1, 1'b0);
    // Ignored start during busy, then back-to-back start in the done cycle
    @(negedge clk); run_op(4'b1000, 32'd3, 32'd4, 1'b1);
    run_op(4'b0010, 32'd1, 32'd2, 1'b0);

    // Reset mid-operation: no done, immediate reset values
    @(negedge clk);
    alucode = 4'b1010; data1 = 32'd1000; data2 = 32'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_dataOut", 64'(dataOut), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_zero", 64'(zero), 64'd1);
    dcnt = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    @(negedge clk); reset = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("abort_no_done", 64'(dcnt), 64'd0);
    @(negedge clk); run_op(4'b1010, 32'd1000, 32'd3, 1'b0);

    // Random operations
    for (int i = 0; i < 24; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom);
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        default: rb = 32'($urandom);
      endcase
      @(negedge clk);
      run_op(rop, ra, rb, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU.
- Keeps the existing logic/arithmetic opcodes, executed in 1 cycle.
- Adds iterative unsigned multiply (low/high word) and divide/remainder, executed one bit per cycle.
- Sits in the execute stage behind a start/busy/done handshake so the controller can stall on long operations.

Parameters:
- WIDTH, 32, operand and result width in bits (>= 4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only while busy=0
- alucode  input  4  operation select, latched with start
- data1  input  WIDTH  operand A / dividend, latched with start
- data2  input  WIDTH  operand B / divisor, latched with start
- busy  output  1  high while an iterative operation is in progress
- done  output  1  one-cycle pulse; result and flags valid in this cycle
- dataOut  output  WIDTH  registered result; holds until the next done
- zero  output  1  registered (dataOut == 0), updated with dataOut
- div_by_zero  output  1  registered; set with done for DIVU/REMU when divisor is 0, else cleared with done

Behaviour:
- Reset (async, any state) forces state=IDLE, dataOut=0, done=0, busy=0, zero=1, div_by_zero=0, counter=0. Internal operand/accumulator registers clear to 0.
- Opcodes and results (all unsigned; arithmetic wraps mod 2^WIDTH):
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0111 SLT (1 if data1<data2, else 0)
  - 1100 NOR
  - 1000 MULLO (low WIDTH bits of the product)
  - 1001 MULHI (high WIDTH bits of the 2*WIDTH product)
  - 1010 DIVU (quotient)
  - 1011 REMU (remainder)
  - Any other code: dataOut=0, simple latency.
- FSM states: IDLE, CALC.
  - IDLE: busy=0.
    - On an edge with start=1 and a simple opcode: dataOut, zero and div_by_zero=0 are written, done=1 for the next cycle, and the state stays IDLE. Latency is 1 edge.
    - On an edge with start=1 and an iterative opcode (1000-1011): operands and opcode are latched, accumulators are initialised, counter=0, state goes to CALC.
  - CALC: busy=1.
    - Each edge performs one iteration: shift-add for multiply, restoring shift-subtract for divide. The counter increments.
    - The edge on which the counter reaches WIDTH writes dataOut, zero and div_by_zero, sets done=1, and returns to IDLE.
    - Iterative latency is exactly WIDTH+1 edges from the start edge; busy is high for WIDTH cycles.
- done is high for exactly one cycle per accepted start and is 0 in every other cycle.
- start while busy=1 is ignored (not queued). data1/data2/alucode changes during CALC have no effect.
- In the cycle where done=1, busy=0, so a start sampled on the next edge is accepted (back-to-back operation).
- Divide by zero (data2=0):
  - Runs the full WIDTH+1 latency.
  - DIVU result = all ones; REMU result = dividend.
  - div_by_zero=1 with done.
- Reset asserted mid-CALC aborts the operation: no done pulse, outputs go to reset values immediately. The first start after reset release is handled normally.
- dataOut is never combinationally dependent on the inputs; all outputs are flop outputs.

Test Plan (WIDTH=32):
1. ADD, data1=0xFFFFFFFF, data2=1, start one cycle -> next cycle: done=1, dataOut=0, zero=1, busy never high. SUB 5-7 -> 0xFFFFFFFE; SLT 3,7 -> 1; opcode 0101 -> 0, zero=1.
2. MULLO 0x00010000 × 0x00010000 -> dataOut=0, zero=1, done on edge 33 after start, busy high for exactly 32 cycles. MULHI with the same operands -> dataOut=1. MULLO 12345×678 -> 8369910.
3. DIVU 100/7 -> dataOut=14. REMU 100/7 -> 2. DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF. div_by_zero=0 in all three cases.
4. DIVU 55/0 -> 0xFFFFFFFF, div_by_zero=1. REMU 55/0 -> 55, div_by_zero=1. A following ADD 1+1 -> 2, div_by_zero=0.
5. Start MULLO 3×4, then pulse start with ADD 9+9 and change data1/data2 at cycles 5 and 10 -> single done at edge 33 with dataOut=12, and no second done. Assert start with ADD 1+2 during the done cycle -> done one cycle later, dataOut=3.
6. Start DIVU 1000/3, assert reset at cycle 10 for 2 cycles -> immediately dataOut=0, busy=0, done=0, zero=1, and no done pulse. After release, DIVU 1000/3 -> 333 after 33 edges.
